// File: rtl/bdm_pkg.sv
// Shared BDM definitions: responder FSM state encoding and default BDC timing constants,
// also used by sync_controller.
package bdm_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MEAS    = 3'd1;
  localparam logic [2:0] ST_DELAY   = 3'd2;
  localparam logic [2:0] ST_PULSE   = 3'd3;
  localparam logic [2:0] ST_SPEEDUP = 3'd4;
  localparam logic [2:0] ST_RECOVER = 3'd5;

  localparam int CLKS_PER_BDC_DEF = 16;
  localparam int SYNC_REQ_BDC_DEF = 128;
  localparam int DELAY_BDC_DEF    = 16;
  localparam int PULSE_BDC_DEF    = 128;
  localparam int CNT_W_DEF        = 16;

  // Speed-up pulse is a quarter BDC period, never shorter than one clk.
  function automatic int speedup_clks(input int clks_per_bdc);
    return (clks_per_bdc / 4 < 1) ? 1 : clks_per_bdc / 4;
  endfunction

endpackage

// File: rtl/bdm_bkgd_sync.sv
// Two-flop synchronizer for the raw BKGD pad level; resets to 1 to match the idle-high bus.
module bdm_bkgd_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bdm_sync_responder.sv
// Target-side BDM SYNC responder: qualifies a long host low on BKGD and answers with a timed low pulse.
// Optional active-high speed-up pulse after the response is enabled by BDM_SYNC_SPEEDUP_EN.
//
// state   | meaning
// IDLE    | bus idle, waiting for a host low
// MEAS    | measuring host low time
// DELAY   | qualified request, waiting before the response
// PULSE   | driving the response low pulse
// SPEEDUP | actively driving BKGD high after the pulse
// RECOVER | flushing own pulse out of the synchronizer
module bdm_sync_responder
  import bdm_pkg::*;
#(
  parameter int CLKS_PER_BDC = CLKS_PER_BDC_DEF,
  parameter int SYNC_REQ_BDC = SYNC_REQ_BDC_DEF,
  parameter int DELAY_BDC    = DELAY_BDC_DEF,
  parameter int PULSE_BDC    = PULSE_BDC_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             bkgd_in,
  output logic             bkgd,
  output logic             bkgd_drive_high,
  output logic             is_sending,
  output logic             sync_detected,
  output logic [CNT_W-1:0] low_len
);

  localparam logic [CNT_W-1:0] REQ     = CNT_W'(SYNC_REQ_BDC * CLKS_PER_BDC);
  localparam logic [CNT_W-1:0] DLY_TC  = CNT_W'(DELAY_BDC * CLKS_PER_BDC - 1);
  localparam logic [CNT_W-1:0] PLS_TC  = CNT_W'(PULSE_BDC * CLKS_PER_BDC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef BDM_SYNC_SPEEDUP_EN
  localparam logic [CNT_W-1:0] SPD_TC  = CNT_W'(speedup_clks(CLKS_PER_BDC) - 1);
`endif

  logic             bkgd_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

  bdm_bkgd_sync u_bkgd_sync (
    .clk (clk),
    .rst (rst),
    .d   (bkgd_in),
    .q   (bkgd_s)
  );

  // cnt counts up while measuring; DELAY/PULSE/SPEEDUP/RECOVER load it and count down to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      bkgd            <= 1'b0;
      bkgd_drive_high <= 1'b0;
      is_sending      <= 1'b0;
      sync_detected   <= 1'b0;
      low_len         <= '0;
    end else begin
      sync_detected <= 1'b0;
      if (!enable) begin
        state           <= ST_IDLE;
        cnt             <= '0;
        bkgd            <= 1'b0;
        bkgd_drive_high <= 1'b0;
        is_sending      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!bkgd_s) begin
              state <= ST_MEAS;
              cnt   <= CNT_ONE;
            end
          end
          ST_MEAS: begin
            if (bkgd_s) begin
              if (cnt >= REQ) begin
                low_len       <= cnt;
                sync_detected <= 1'b1;
                state         <= ST_DELAY;
                cnt           <= DLY_TC;
              end else begin
                state <= ST_IDLE;
              end
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_DELAY: begin
            // A new host low here means the host gave up and restarted its request.
            if (!bkgd_s) begin
              state <= ST_MEAS;
              cnt   <= CNT_ONE;
            end else if (cnt == '0) begin
              state      <= ST_PULSE;
              bkgd       <= 1'b1;
              is_sending <= 1'b1;
              cnt        <= PLS_TC;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          ST_PULSE: begin
            if (cnt == '0) begin
              bkgd <= 1'b0;
`ifdef BDM_SYNC_SPEEDUP_EN
              state           <= ST_SPEEDUP;
              bkgd_drive_high <= 1'b1;
              cnt             <= SPD_TC;
`else
              state      <= ST_RECOVER;
              is_sending <= 1'b0;
              cnt        <= CNT_ONE;
`endif
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          ST_SPEEDUP: begin
`ifdef BDM_SYNC_SPEEDUP_EN
            if (cnt == '0) begin
              state           <= ST_RECOVER;
              bkgd_drive_high <= 1'b0;
              is_sending      <= 1'b0;
              cnt             <= CNT_ONE;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
`else
            state <= ST_RECOVER;
            cnt   <= CNT_ONE;
`endif
          end
          ST_RECOVER: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_ONE;
            end else if (bkgd_s) begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
